// File: rtl/issue_queue_if.sv
// Dispatch/wakeup/issue signal bundle for one issue_queue instance.
// The queue takes the slave modport; the dispatch/FU environment takes master.
interface issue_queue_if #(
    parameter int IQ_SIZE        = 16,
    parameter int ISSUE_WIDTH    = 2,
    parameter int WAKEUP_WIDTH   = 4,
    parameter int PREG_WIDTH     = 6,
    parameter int DISPATCH_WIDTH = 4,
    parameter int UOP_W          = 1 + 3 * PREG_WIDTH + 8
);
    logic                                         flush_i;
    logic [DISPATCH_WIDTH-1:0][UOP_W-1:0]         uop_i;
    logic [DISPATCH_WIDTH-1:0][1:0]               src_ready_i;
    logic                                         ready_o;
    logic [WAKEUP_WIDTH-1:0]                      wakeup_valid_i;
    logic [WAKEUP_WIDTH-1:0][PREG_WIDTH-1:0]      wakeup_preg_i;
    logic [ISSUE_WIDTH-1:0]                       fu_ready_i;
    logic [ISSUE_WIDTH-1:0][UOP_W-1:0]            uop_o;
    logic [$clog2(IQ_SIZE+1)-1:0]                 count_o;

    modport master (
        output flush_i, uop_i, src_ready_i, wakeup_valid_i, wakeup_preg_i, fu_ready_i,
        input  ready_o, uop_o, count_o
    );

    modport slave (
        input  flush_i, uop_i, src_ready_i, wakeup_valid_i, wakeup_preg_i, fu_ready_i,
        output ready_o, uop_o, count_o
    );
endinterface

// File: rtl/issue_queue.sv
// Collapsing, age-ordered issue queue with tag wakeup and oldest-first multi-issue.
// Optional macro IQ_ISSUE_REG_EN registers uop_o (one cycle of added issue latency).
module issue_queue #(
    parameter int IQ_SIZE        = 16,
    parameter int ISSUE_WIDTH    = 2,
    parameter int WAKEUP_WIDTH   = 4,
    parameter int PREG_WIDTH     = 6,
    parameter int DISPATCH_WIDTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    issue_queue_if.slave io
);
    localparam int CW = $clog2(IQ_SIZE + 1);

    typedef struct packed {
        logic                  valid;
        logic [PREG_WIDTH-1:0] rs1_preg;
        logic [PREG_WIDTH-1:0] rs2_preg;
        logic [PREG_WIDTH-1:0] rd_preg;
        logic [7:0]            tag;
    } micro_op_t;

    function automatic logic wake_hit(
        input logic [PREG_WIDTH-1:0]                  preg,
        input logic [WAKEUP_WIDTH-1:0]                wv,
        input logic [WAKEUP_WIDTH-1:0][PREG_WIDTH-1:0] wp
    );
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < WAKEUP_WIDTH; j++) begin
            hit = hit | (wv[j] && (wp[j] == preg));
        end
        return hit;
    endfunction

    micro_op_t          uop_q [IQ_SIZE];
    micro_op_t          uop_d [IQ_SIZE];
    logic [IQ_SIZE-1:0] vld_q, vld_d;
    logic [IQ_SIZE-1:0] rs1_rdy_q, rs1_rdy_d;
    logic [IQ_SIZE-1:0] rs2_rdy_q, rs2_rdy_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ready;

    logic [IQ_SIZE-1:0] elig;
    logic [IQ_SIZE-1:0] issue_mask;
    logic [CW-1:0]      elig_rank [IQ_SIZE];
    logic [CW-1:0]      fu_rank   [ISSUE_WIDTH];
    logic [CW-1:0]      fu_cnt, elig_cnt;
    micro_op_t          sel_uop   [ISSUE_WIDTH];

    logic [CW-1:0]      surv_cnt, acc_cnt;
    logic               grp_open;
    micro_op_t          in_uop;

    // Stall is based on current occupancy only, so fu_ready never reaches ready_o.
    assign ready      = (CW'(IQ_SIZE) - count_q) >= CW'(DISPATCH_WIDTH);
    assign io.ready_o = ready;
    assign io.count_o = count_q;

    // The n-th oldest eligible entry goes to the n-th FU that is ready.
    always_comb begin
        fu_cnt     = '0;
        elig_cnt   = '0;
        elig       = '0;
        issue_mask = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            fu_rank[k] = fu_cnt;
            fu_cnt     = fu_cnt + CW'(io.fu_ready_i[k]);
        end
        for (int i = 0; i < IQ_SIZE; i++) begin
            elig[i]       = vld_q[i] & rs1_rdy_q[i] & rs2_rdy_q[i];
            elig_rank[i]  = elig_cnt;
            issue_mask[i] = elig[i] && (elig_cnt < fu_cnt);
            elig_cnt      = elig_cnt + CW'(elig[i]);
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            sel_uop[k] = '0;
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (issue_mask[i] && io.fu_ready_i[k] && (elig_rank[i] == fu_rank[k])) begin
                    sel_uop[k] = uop_q[i];
                end
            end
        end
    end

    always_comb begin
        vld_d     = '0;
        rs1_rdy_d = '0;
        rs2_rdy_d = '0;
        surv_cnt  = '0;
        acc_cnt   = '0;
        grp_open  = ready;
        in_uop    = '0;
        for (int d = 0; d < IQ_SIZE; d++) begin
            uop_d[d] = uop_q[d];
        end

        // Survivors compact toward index 0 keeping age order.
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (vld_q[i] && !issue_mask[i]) begin
                for (int d = 0; d < IQ_SIZE; d++) begin
                    if (CW'(d) == surv_cnt) begin
                        uop_d[d]     = uop_q[i];
                        vld_d[d]     = 1'b1;
                        rs1_rdy_d[d] = rs1_rdy_q[i] |
                            wake_hit(uop_q[i].rs1_preg, io.wakeup_valid_i, io.wakeup_preg_i);
                        rs2_rdy_d[d] = rs2_rdy_q[i] |
                            wake_hit(uop_q[i].rs2_preg, io.wakeup_valid_i, io.wakeup_preg_i);
                    end
                end
                surv_cnt = surv_cnt + CW'(1);
            end
        end

        // Dispatch group is appended; the first invalid slot closes it.
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            in_uop   = micro_op_t'(io.uop_i[s]);
            grp_open = grp_open & in_uop.valid;
            if (grp_open) begin
                for (int d = 0; d < IQ_SIZE; d++) begin
                    if (CW'(d) == (surv_cnt + acc_cnt)) begin
                        uop_d[d]     = in_uop;
                        vld_d[d]     = 1'b1;
                        rs1_rdy_d[d] = io.src_ready_i[s][0] |
                            wake_hit(in_uop.rs1_preg, io.wakeup_valid_i, io.wakeup_preg_i);
                        rs2_rdy_d[d] = io.src_ready_i[s][1] |
                            wake_hit(in_uop.rs2_preg, io.wakeup_valid_i, io.wakeup_preg_i);
                    end
                end
                acc_cnt = acc_cnt + CW'(1);
            end
        end

        count_d = surv_cnt + acc_cnt;
        if (io.flush_i) begin
            vld_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
        end
        rs1_rdy_q <= rs1_rdy_d;
        rs2_rdy_q <= rs2_rdy_d;
        for (int i = 0; i < IQ_SIZE; i++) begin
            uop_q[i] <= uop_d[i];
        end
    end

`ifdef IQ_ISSUE_REG_EN
    micro_op_t uop_out_q [ISSUE_WIDTH];

    always_ff @(posedge clock) begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (reset || io.flush_i) begin
                uop_out_q[k] <= '0;
            end else begin
                uop_out_q[k] <= sel_uop[k];
            end
        end
    end

    always_comb begin
        io.uop_o = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            io.uop_o[k] = uop_out_q[k];
        end
    end
`else
    always_comb begin
        io.uop_o = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            io.uop_o[k] = sel_uop[k];
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: per-cycle issue outputs, occupancy and stall flag.
module tb_issue_queue;
    localparam int UW = 27;
`ifdef IQ_ISSUE_REG_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks;
    int   errors;
    logic [UW-1:0] last_e0, last_e1;
    logic          last_flush;

    always #5 clk = ~clk;

    issue_queue_if io ();

    issue_queue dut (
        .clock (clk),
        .reset (rst),
        .io    (io)
    );

    function automatic logic [UW-1:0] mk(input logic [5:0] r1, input logic [5:0] r2,
                                         input logic [7:0] tag);
        return {1'b1, r1, r2, 6'd0, tag};
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        io.flush_i        = 1'b0;
        io.uop_i          = '0;
        io.src_ready_i    = '0;
        io.wakeup_valid_i = '0;
        io.wakeup_preg_i  = '0;
    endtask

    // Checks this cycle's issue slots, then advances to just after the next edge.
    task automatic cyc(input logic [UW-1:0] e0, input logic [UW-1:0] e1, input string nm);
        logic [UW-1:0] w0, w1;
        @(negedge clk);
        w0 = REG_OUT ? (last_flush ? '0 : last_e0) : e0;
        w1 = REG_OUT ? (last_flush ? '0 : last_e1) : e1;
        chk(32'(io.uop_o[0]), 32'(w0), {nm, ".slot0"});
        chk(32'(io.uop_o[1]), 32'(w1), {nm, ".slot1"});
        last_e0    = e0;
        last_e1    = e1;
        last_flush = io.flush_i | rst;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input int cnt, input logic rdy, input string nm);
        chk(32'(io.count_o), 32'(cnt), {nm, ".count"});
        chk(32'(io.ready_o), 32'(rdy), {nm, ".ready"});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        io.fu_ready_i = '0;
        clr_in();
        last_e0       = '0;
        last_e1       = '0;
        last_flush    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_state(0, 1'b1, "reset");

        // Four ready uops: two issue per cycle, oldest first.
        io.fu_ready_i = 2'b11;
        for (int s = 0; s < 4; s++) begin
            io.uop_i[s]       = mk(6'd1, 6'd2, 8'(s + 1));
            io.src_ready_i[s] = 2'b11;
        end
        cyc('0, '0, "t1.write");
        chk_state(4, 1'b1, "t1.after_write");
        clr_in();
        cyc(mk(6'd1, 6'd2, 8'd1), mk(6'd1, 6'd2, 8'd2), "t1.issue_a");
        chk_state(2, 1'b1, "t1.after_issue_a");
        cyc(mk(6'd1, 6'd2, 8'd3), mk(6'd1, 6'd2, 8'd4), "t1.issue_b");
        chk_state(0, 1'b1, "t1.after_issue_b");

        // Older uop waits on p5; younger ready uop bypasses it.
        io.uop_i[0]       = mk(6'd5, 6'd1, 8'h10);
        io.src_ready_i[0] = 2'b10;
        io.uop_i[1]       = mk(6'd2, 6'd3, 8'h11);
        io.src_ready_i[1] = 2'b11;
        cyc('0, '0, "t2.write");
        chk_state(2, 1'b1, "t2.after_write");
        clr_in();
        cyc(mk(6'd2, 6'd3, 8'h11), '0, "t2.young_first");
        chk_state(1, 1'b1, "t2.after_young");
        cyc('0, '0, "t2.old_waits");
        io.wakeup_valid_i    = 4'b0100;
        io.wakeup_preg_i[2]  = 6'd5;
        cyc('0, '0, "t2.wake_cycle");
        clr_in();
        chk_state(1, 1'b1, "t2.after_wake");
        cyc(mk(6'd5, 6'd1, 8'h10), '0, "t2.old_issues");
        chk_state(0, 1'b1, "t2.drained");

        // Wakeup coinciding with write-in is captured.
        io.uop_i[0]         = mk(6'd7, 6'd7, 8'h30);
        io.src_ready_i[0]   = 2'b00;
        io.wakeup_valid_i   = 4'b1000;
        io.wakeup_preg_i[3] = 6'd7;
        cyc('0, '0, "t3.write_wake");
        clr_in();
        chk_state(1, 1'b1, "t3.after_write");
        cyc(mk(6'd7, 6'd7, 8'h30), '0, "t3.issue");
        chk_state(0, 1'b1, "t3.drained");

        // Fill with non-ready uops; entry 0 waits on p30, the rest on p40.
        for (int g = 0; g < 3; g++) begin
            for (int s = 0; s < 4; s++) begin
                io.uop_i[s] = (g == 0 && s == 0) ? mk(6'd30, 6'd30, 8'h20)
                                                 : mk(6'd40, 6'd40, 8'(32 + 4 * g + s));
            end
            cyc('0, '0, "t4.fill");
        end
        chk_state(12, 1'b1, "t4.twelve");
        io.uop_i[0]       = mk(6'd40, 6'd40, 8'h2C);
        io.uop_i[1]       = '0;
        io.uop_i[2]       = mk(6'd1, 6'd1, 8'hEE);
        io.src_ready_i[2] = 2'b11;
        cyc('0, '0, "t4.fill13");
        clr_in();
        chk_state(13, 1'b0, "t4.thirteen");

        for (int s = 0; s < 4; s++) begin
            io.uop_i[s]       = mk(6'd3, 6'd3, 8'(80 + s));
            io.src_ready_i[s] = 2'b11;
        end
        io.wakeup_valid_i   = 4'b0001;
        io.wakeup_preg_i[0] = 6'd30;
        cyc('0, '0, "t4.held");
        chk_state(13, 1'b0, "t4.held_not_written");
        io.wakeup_valid_i = '0;
        cyc(mk(6'd30, 6'd30, 8'h20), '0, "t4.issue_one");
        chk_state(12, 1'b1, "t4.space_opened");
        cyc('0, '0, "t4.group_in");
        clr_in();
        chk_state(16, 1'b0, "t4.full");

        // FU availability steers the oldest eligible entry.
        io.fu_ready_i = 2'b10;
        cyc('0, mk(6'd3, 6'd3, 8'h50), "t5.fu_10");
        chk_state(15, 1'b0, "t5.after_fu_10");
        io.fu_ready_i = 2'b01;
        cyc(mk(6'd3, 6'd3, 8'h51), '0, "t5.fu_01");
        chk_state(14, 1'b0, "t5.after_fu_01");
        io.fu_ready_i = 2'b11;
        cyc(mk(6'd3, 6'd3, 8'h52), mk(6'd3, 6'd3, 8'h53), "t5.order_kept");
        chk_state(12, 1'b1, "t5.after_order");

        // Flush with a concurrent write and two issues.
        io.wakeup_valid_i   = 4'b0010;
        io.wakeup_preg_i[1] = 6'd40;
        cyc('0, '0, "t6.wake_all");
        clr_in();
        chk_state(12, 1'b1, "t6.before_flush");
        io.flush_i = 1'b1;
        for (int s = 0; s < 4; s++) begin
            io.uop_i[s]       = mk(6'd1, 6'd1, 8'(96 + s));
            io.src_ready_i[s] = 2'b11;
        end
        cyc(mk(6'd40, 6'd40, 8'h21), mk(6'd40, 6'd40, 8'h22), "t6.flush_cycle");
        clr_in();
        chk_state(0, 1'b1, "t6.after_flush");
        cyc('0, '0, "t6.quiet");
        chk_state(0, 1'b1, "t6.still_empty");

        // Reset mid-operation drops queued work.
        io.uop_i[0]       = mk(6'd4, 6'd4, 8'h70);
        io.uop_i[1]       = mk(6'd4, 6'd4, 8'h71);
        io.src_ready_i[0] = 2'b11;
        io.src_ready_i[1] = 2'b11;
        cyc('0, '0, "t7.write");
        clr_in();
        chk_state(2, 1'b1, "t7.after_write");
        rst = 1'b1;
        cyc(mk(6'd4, 6'd4, 8'h70), mk(6'd4, 6'd4, 8'h71), "t7.reset_cycle");
        rst = 1'b0;
        chk_state(0, 1'b1, "t7.after_reset");
        cyc('0, '0, "t7.quiet");
        chk_state(0, 1'b1, "t7.still_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
# issue_queue

Receiving end of dispatch: one instance per `iq_code` (IQ_INT, IQ_MEM, IQ_AP) buffers the packed `micro_op_t` vector that dispatch emits for that queue. Each entry tracks operand readiness from physical-register wakeup broadcasts. The queue issues up to ISSUE_WIDTH ready uops per cycle, oldest first, to its functional units. Storage is collapsing and age-ordered: entry 0 is always the oldest.

## Interface
- `IQ_SIZE`, 16: number of entries.
- `ISSUE_WIDTH`, 2: issue slots per cycle.
- `WAKEUP_WIDTH`, 4: wakeup tag broadcasts per cycle.
- `PREG_WIDTH`, 6: physical register tag width.
- `clock`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `flush`, in, 1: discard all entries (mispredict recovery).
- `uop_in`, in, `DISPATCH_WIDTH` x `micro_op_t`: from dispatch. Valid slots are packed at low indices; the first invalid slot ends the group.
- `src_ready_in`, in, `DISPATCH_WIDTH` x 2: busy-table readiness of rs1/rs2 per incoming slot.
- `ready_out`, out, 1: the queue can accept a full dispatch group this cycle.
- `wakeup_valid`, in, `WAKEUP_WIDTH`: tag strobes.
- `wakeup_preg`, in, `WAKEUP_WIDTH` x `PREG_WIDTH`: produced physical register tags.
- `fu_ready`, in, `ISSUE_WIDTH`: FU k can accept a uop this cycle.
- `uop_out`, out, `ISSUE_WIDTH` x `micro_op_t`: issued uops. A non-issuing slot drives all-zero, so `.valid` = 0.
- `count`, out, `$clog2(IQ_SIZE+1)`: occupied entries.

## Operation
- Each entry holds a `micro_op_t`, `rs1_rdy`, `rs2_rdy` and an entry valid bit. Entries are contiguous from index 0 in age order.
- Wakeup: an entry's `rsN_rdy` is set when any `wakeup_valid[j]` is high and `wakeup_preg[j]` equals `uop.rsN_preg`. A set `rsN_rdy` stays set until the entry leaves.
- Write-in occurs when `ready_out` is high.
  - Incoming slot i initialises `rsN_rdy` to `src_ready_in[i][N]` OR a same-cycle wakeup match.
  - Accepted slots are appended after the survivors, in slot order.
- Write-in while `ready_out` is low:
  - `uop_in` is ignored.
  - Dispatch must hold its group; `ready_out` low is the stall signal.
- Issue select:
  - An entry is eligible when it is valid and both `rsN_rdy` bits are set.
  - Issue slot 0 takes the oldest eligible entry; slot 1 takes the next oldest.
  - Slot k issues only if `fu_ready[k]` is high. If `fu_ready[0]` is low, the oldest eligible entry moves to slot 1 when `fu_ready[1]` is high.
- Collapse: issued entries are removed at the clock edge and the survivors shift down, preserving order.
- `ready_out` = (`IQ_SIZE` − `count`) >= `DISPATCH_WIDTH`. It is computed from the current `count` only and ignores same-cycle issue, so there is no combinational path from `fu_ready`.
- `count` next value = `count` − issued + accepted.
- `flush` clears all entry valid bits and sets `count` to 0. It overrides same-cycle write-in and issue. `uop_out` still follows the Configuration rules for that cycle's selection.

## Timing
- Reset values:
  - `count` = 0.
  - All entries invalid.
  - `ready_out` = 1.
  - `uop_out` all zero.
- Write at edge t: the entry is eligible for select in cycle t+1 at the earliest. A uop is never issued in the cycle it is written.
- Wakeup in cycle t is visible to select in cycle t+1.
- With exactly `DISPATCH_WIDTH` entries free, the queue accepts a full group and `ready_out` drops the following cycle.
- Reset or `flush` mid-operation discards everything in flight, with no partial issue.

## Configuration
- `IQ_ISSUE_REG_EN` defined:
  - `uop_out` is registered; a uop selected in cycle t appears on `uop_out` in cycle t+1.
  - `fu_ready` is sampled in cycle t.
  - `flush` in cycle t forces `uop_out` to zero in cycle t+1.
- Undefined:
  - `uop_out` is combinational from the cycle-t selection, with zero added latency.
  - `flush` in cycle t does not suppress that cycle's combinational `uop_out`.

## Test plan
- After reset, dispatch 4 uops with all sources ready, `fu_ready`=2'b11 → the two oldest issue in cycle 1 and the next two in cycle 2; `count` goes 4, 2, 0.
- Uop A rs1=p5 not ready, uop B younger and ready → B issues first. Wakeup p5 in cycle 3 → A issues in cycle 4.
- Wakeup of p7 in the same cycle as a uop with rs1=p7, `src_ready_in`=0, is written → the uop issues the next cycle.
- Fill to 13 entries with no wakeups → `ready_out`=0 and a held group is not written. Issue one entry → `ready_out`=1 the next cycle; the group writes and `count`=16.
- `fu_ready`=2'b10 with 3 eligible entries → only the oldest issues, on slot 1; the other two remain in order.
- `flush` asserted together with a 4-uop write and 2 issues → `count`=0 next cycle and `ready_out`=1. `uop_out` is zero next cycle with `IQ_ISSUE_REG_EN`; without it, that cycle's combinational output stands.
